// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit, one bit per cycle.
// Ports: valid_i/ready_o request, valid_o/ready_i result, kill_i abort, busy_o stall.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                valid_q, valid_d;

    // operand decode at accept
    logic            is_div, s1_en, s2_en, neg1, neg2;
    logic [XLEN-1:0] mag1, mag2, fast_res;
    logic            div0, ovf;

    // iteration datapath
    logic [XLEN:0]     mul_sum, div_cand, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, step, prod;
    logic [XLEN-1:0]   dv, fin;

    assign ready_o = (state_q == IDLE) && !kill_i;
    assign valid_o = valid_q;
    assign res_o   = res_q;
    assign busy_o  = (state_q != IDLE);

    always_comb begin
        is_div = funct3_i[2];
        // signed operands: MULH both, MULHSU op1 only, DIV/REM both
        s1_en  = is_div ? !funct3_i[0]
                        : (funct3_i[1:0] == 2'd1) || (funct3_i[1:0] == 2'd2);
        s2_en  = is_div ? !funct3_i[0] : (funct3_i[1:0] == 2'd1);
        neg1   = s1_en && op1_i[XLEN-1];
        neg2   = s2_en && op2_i[XLEN-1];
        mag1   = neg1 ? -op1_i : op1_i;
        mag2   = neg2 ? -op2_i : op2_i;
        div0   = is_div && (op2_i == '0);
        ovf    = is_div && !funct3_i[0]
                 && (op1_i == {1'b1, {(XLEN-1){1'b0}}})
                 && (op2_i == '1);
        if (div0) begin
            fast_res = funct3_i[1] ? op1_i : '1;
        end else begin
            fast_res = funct3_i[1] ? '0 : op1_i;
        end
    end

    always_comb begin
        // multiply: conditional add into the high half, then shift right
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        // restoring divide: {rem, quot} shifted left, trial subtract
        div_cand = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_cand - {1'b0, b_q};
        if (!div_diff[XLEN]) begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {div_cand[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        step = op_q[2] ? div_next : mul_next;
        prod = neg_q ? -step : step;
        dv   = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        if (op_q[2]) begin
            fin = neg_q ? -dv : dv;
        end else if (op_q[1:0] == 2'd0) begin
            fin = prod[XLEN-1:0];
        end else begin
            fin = prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        res_d   = res_q;
        valid_d = valid_q;
        if (kill_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_d = funct3_i;
                        if (div0 || ovf) begin
                            res_d   = fast_res;
                            valid_d = 1'b1;
                            state_d = DONE;
                        end else begin
                            cnt_d   = CNT_W'(XLEN);
                            state_d = CALC;
                            if (is_div) begin
                                acc_d = {{XLEN{1'b0}}, mag1};
                                b_d   = mag2;
                                neg_d = funct3_i[1] ? neg1 : (neg1 ^ neg2);
                            end else begin
                                acc_d = {{XLEN{1'b0}}, mag2};
                                b_d   = mag1;
                                neg_d = neg1 ^ neg2;
                            end
                        end
                    end
                end
                CALC: begin
                    acc_d = step;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        res_d   = fin;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and model-based bench for muldiv_unit at XLEN=32.
// Covers latency, fast paths, backpressure, kill and async reset.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] res_o;
    logic        busy_o;

    int n_run = 0;
    int n_fail = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .funct3_i (funct3_i),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .res_o    (res_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r = '0;
        case (f)
            3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        return f[2] && ((b == 0) ||
               (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic start(input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        while (!ready_o && w < 100) begin
            @(posedge clk_i); #1; w++;
        end
        chk({tag, "_rdy"}, {31'b0, ready_o}, 32'd1);
        valid_i = 1'b1;
        funct3_i = f;
        op1_i = a;
        op2_i = b;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        op1_i = 32'hDEAD_BEEF;
        op2_i = 32'h1234_5678;
        funct3_i = 3'd0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(posedge clk_i); #1; lat++;
        end
    endtask

    task automatic consume();
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        int lat;
        start(tag, f, a, b);
        wait_valid(lat);
        chk({tag, "_res"}, res_o, exp);
        chk({tag, "_lat"}, 32'(lat), is_fast(f, a, b) ? 32'd0 : 32'd32);
        consume();
        chk({tag, "_idle"}, {31'b0, ready_o}, 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [2:0]  f;
        logic [31:0] a, b;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_res", res_o, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_ready", {31'b0, ready_o}, 32'd1);

        run("mul",    3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        run("mulh",   3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run("mulhu",  3'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
        run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run("divu",   3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        run("remu",   3'd7, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001);
        run("divu0",  3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run("rem0",   3'd6, 32'd5, 32'd0, 32'd5);
        run("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run("mulzero", 3'd0, 32'd0, 32'd7, 32'd0);

        // backpressure
        start("bp", 3'd0, 32'd3, 32'd5);
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd32);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'b0, valid_o}, 32'd1);
            chk("bp_res", res_o, 32'd15);
            chk("bp_ready", {31'b0, ready_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        consume();
        chk("bp_after_ready", {31'b0, ready_o}, 32'd1);
        chk("bp_after_valid", {31'b0, valid_o}, 32'd0);
        run("bp_next", 3'd5, 32'd1000, 32'd3, 32'd333);

        // kill mid-divide
        start("kill", 3'd4, 32'd100, 32'd7);
        repeat (14) begin
            @(posedge clk_i); #1;
        end
        kill_i = 1'b1;
        #1;
        chk("kill_mask_ready", {31'b0, ready_o}, 32'd0);
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        chk("kill_valid", {31'b0, valid_o}, 32'd0);
        chk("kill_busy", {31'b0, busy_o}, 32'd0);
        chk("kill_res_kept", res_o, 32'd333);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) seen++;
            @(posedge clk_i); #1;
        end
        chk("kill_no_result", 32'(seen), 32'd0);
        run("kill_next", 3'd3, 32'h8000_0000, 32'd4, 32'd2);

        // kill together with valid in IDLE
        kill_i = 1'b1;
        valid_i = 1'b1;
        funct3_i = 3'd0;
        op1_i = 32'd9;
        op2_i = 32'd9;
        #1;
        chk("killv_ready", {31'b0, ready_o}, 32'd0);
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        valid_i = 1'b0;
        chk("killv_busy", {31'b0, busy_o}, 32'd0);

        // kill beats ready_i in DONE
        start("killd", 3'd5, 32'd9, 32'd0);
        chk("killd_valid_pre", {31'b0, valid_o}, 32'd1);
        kill_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        ready_i = 1'b0;
        chk("killd_valid", {31'b0, valid_o}, 32'd0);
        chk("killd_busy", {31'b0, busy_o}, 32'd0);

        // sweep against the reference model
        for (int i = 0; i < 24; i++) begin
            f = 3'(i % 8);
            a = $urandom;
            b = $urandom;
            if (i % 8 == 5) b = b >> $urandom_range(31, 0);
            if (i == 12) b = 32'd0;
            if (i == 20) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (i == 22) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run($sformatf("sweep%0d", i), f, a, b, model(f, a, b));
        end

        // async reset mid-calc
        start("arst", 3'd0, 32'd12345, 32'd678);
        repeat (10) begin
            @(posedge clk_i); #1;
        end
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", {31'b0, valid_o}, 32'd0);
        chk("arst_res", res_o, 32'd0);
        chk("arst_busy", {31'b0, busy_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("arst_ready", {31'b0, ready_o}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) seen++;
            @(posedge clk_i); #1;
        end
        chk("arst_no_valid", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
